imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream loader that fills the CPU's writable instruction memory at run time. The reference ROM image is fixed at synthesis, whereas this block accepts a length-prefixed, big-endian byte stream (typically from the UART receiver) and assembles 32-bit instruction words. It issues one write per word into the instruction RAM write port and zero-fills all remaining locations. It holds the CPU in reset for the whole session.

## Interface
Parameters:
- DEPTH_WORDS, 64, number of 32-bit instruction words in the target memory (1..65535).
- ADDR_W, 6, word-address width; must satisfy 2^ADDR_W >= DEPTH_WORDS.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse that begins a load session; honoured only in IDLE.
- ByteValid  in  1  ByteData is valid this cycle.
- ByteData  in  8  incoming stream byte.
- ByteReady  out  1  loader accepts a byte this cycle; a transfer occurs when ByteValid & ByteReady.
- WrEn  out  1  instruction-memory write strobe, one cycle per word.
- WrAddr  out  ADDR_W  word address (CPU byte address >> 2).
- WrData  out  32  word to write.
- CpuHold  out  1  high while a session is active; drives CPU reset.
- Done  out  1  one-cycle pulse on successful completion.
- Error  out  1  sticky length error; cleared by reset or the next accepted Start.

## Operation
- States: IDLE, COUNT_HI, COUNT_LO, DATA, FILL, DONE.
- IDLE:
  - ByteReady=0; ByteValid is ignored and the byte dropped.
  - Start → COUNT_HI, and Error is cleared.
- COUNT_HI / COUNT_LO:
  - ByteReady=1.
  - Accepted bytes form the 16-bit word count N, high byte first.
  - After COUNT_LO is accepted:
    - If N > DEPTH_WORDS → Error=1, return to IDLE, and no writes occur.
    - If N = 0 → FILL.
    - Otherwise → DATA.
- DATA:
  - ByteReady=1.
  - Bytes assemble big-endian: the first byte goes to [31:24] and the fourth to [7:0].
  - Each 4th accepted byte commits the word at word index w (0..N-1), then w increments.
  - After word N-1 is committed: → FILL if N < DEPTH_WORDS, else → DONE.
- FILL:
  - ByteReady=0.
  - Writes WrData=0 to addresses N..DEPTH_WORDS-1, one per cycle, then → DONE.
- DONE:
  - Done=1 and CpuHold=0 for one cycle, then → IDLE.
- Start outside IDLE is ignored; there is no restart mid-session.
- Gaps in ByteValid are allowed anywhere, with no timeout.
- WrAddr is an unsigned word counter and never exceeds DEPTH_WORDS-1. The word counter needs 16 bits internally to compare against N.

## Timing
- Reset values:
  - All outputs are 0: ByteReady, WrEn, WrAddr, WrData, CpuHold, Done, Error.
  - State is IDLE and all counters and the assembly register are 0.
- Reset asserted mid-session:
  - Takes effect at the next edge, so all outputs are 0 the following cycle.
  - Words already written stay in memory; nothing is rolled back.
- All outputs are registered.
- Start sampled at cycle t:
  - CpuHold=1 and ByteReady=1 from t+1.
  - Error clears at t+1.
- Length error, COUNT_LO accepted at t: Error=1, CpuHold=0 and ByteReady=0 at t+1.
- Data writes: the 4th byte of a word accepted at t gives WrEn=1 with that word's WrAddr/WrData at t+1 for exactly one cycle. ByteReady stays 1, so the next word's first byte may be accepted at t+1.
- Timing is measured from the last stream byte accepted at t (the COUNT_LO byte when N=0):
  - Fill writes for addresses N..DEPTH_WORDS-1 appear on consecutive cycles t+2 .. t+1+(DEPTH_WORDS-N).
  - Done=1 at t+2+(DEPTH_WORDS-N), with CpuHold=0 from that same cycle.
  - For N=DEPTH_WORDS: last write at t+1, Done at t+2.
- WrEn is 0 whenever no write is issued. WrData/WrAddr hold their last values, and only their values while WrEn=1 are meaningful.
- In any cycle, at most one byte is accepted and at most one write is issued.

## Test plan
- Reset: hold reset for 2 cycles, including once mid-DATA after 2 bytes → the next cycle has all outputs 0 and the state is IDLE; a fresh Start then performs a normal load.
- Basic load (DEPTH_WORDS=64): Start, then bytes 00 02 08 00 00 03 0C 00 00 1B →
  - WrEn at addr 0 with 0x08000003, then at addr 1 with 0x0C00001B.
  - Zero writes to addrs 2..63 on consecutive cycles.
  - A single Done pulse, and CpuHold falls with Done.
- Empty image: stream 00 00 → 64 zero writes to addrs 0..63 at t+2..t+65, then Done at t+66.
- Length error: stream 00 41 (N=65) → Error=1 at t+1, no WrEn ever, CpuHold=0. Error stays high until the next Start.
- Full image with gaps: N=64 with ByteValid random at about 50% and a Start pulse mid-DATA →
  - The Start is ignored and no fill writes occur.
  - Exactly 64 writes with the correct data, then Done exactly 1 cycle after the last write.
- Idle noise: ByteValid pulses in IDLE without Start → ByteReady=0, no writes, and CpuHold stays 0.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed big-endian byte stream to instruction RAM loader with zero fill
module imem_loader #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic              ByteValid,
    input  logic [7:0]        ByteData,
    output logic              ByteReady,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [31:0]       WrData,
    output logic              CpuHold,
    output logic              Done,
    output logic              Error
);

    typedef enum logic [2:0] {IDLE, COUNT_HI, COUNT_LO, DATA, FILL, DONE} state_t;

    localparam logic [15:0] DEPTH = 16'(DEPTH_WORDS);

    state_t      state;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [23:0] asm_r;
    logic [1:0]  byte_cnt;
    logic        accept;
    logic [15:0] n_next;

    assign accept = ByteValid & ByteReady;
    assign n_next = {count[15:8], ByteData};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            word_idx  <= '0;
            asm_r     <= '0;
            byte_cnt  <= '0;
            ByteReady <= 1'b0;
            WrEn      <= 1'b0;
            WrAddr    <= '0;
            WrData    <= '0;
            CpuHold   <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            WrEn <= 1'b0;
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state     <= COUNT_HI;
                        Error     <= 1'b0;
                        CpuHold   <= 1'b1;
                        ByteReady <= 1'b1;
                        count     <= '0;
                        word_idx  <= '0;
                        asm_r     <= '0;
                        byte_cnt  <= '0;
                    end
                end
                COUNT_HI: begin
                    if (accept) begin
                        count[15:8] <= ByteData;
                        state       <= COUNT_LO;
                    end
                end
                COUNT_LO: begin
                    if (accept) begin
                        count <= n_next;
                        if (n_next > DEPTH) begin
                            Error     <= 1'b1;
                            CpuHold   <= 1'b0;
                            ByteReady <= 1'b0;
                            state     <= IDLE;
                        end else if (n_next == 16'd0) begin
                            ByteReady <= 1'b0;
                            state     <= FILL;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt != 2'd3) begin
                            asm_r <= {asm_r[15:0], ByteData};
                        end else begin
                            // asm_r holds bytes 0..2 in its top..bottom lanes
                            WrEn     <= 1'b1;
                            WrAddr   <= word_idx[ADDR_W-1:0];
                            WrData   <= {asm_r, ByteData};
                            word_idx <= word_idx + 16'd1;
                            if (word_idx == count - 16'd1) begin
                                ByteReady <= 1'b0;
                                state     <= (count < DEPTH) ? FILL : DONE;
                            end
                        end
                    end
                end
                FILL: begin
                    WrEn     <= 1'b1;
                    WrAddr   <= word_idx[ADDR_W-1:0];
                    WrData   <= '0;
                    word_idx <= word_idx + 16'd1;
                    if (word_idx == DEPTH - 16'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    Done    <= 1'b1;
                    CpuHold <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with directed byte streams
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic        ByteValid = 1'b0;
    logic [7:0]  ByteData = 8'h00;
    logic        ByteReady;
    logic        WrEn;
    logic [5:0]  WrAddr;
    logic [31:0] WrData;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH_WORDS(64), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .Start(Start), .ByteValid(ByteValid), .ByteData(ByteData),
        .ByteReady(ByteReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .CpuHold(CpuHold), .Done(Done), .Error(Error)
    );

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0, bad = 0, cyc = 0;
    int  n_wr = 0, n_done = 0, first_wr = -1, last_wr = -1, done_cyc = -1, last_t = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.a = 6'(a);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_stats();
        n_wr = 0; n_done = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
    endtask

    // Monitor: every write is popped against the scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (WrEn) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(WrAddr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(WrAddr), 32'(e.a));
                chk("wr_data", WrData, e.d);
            end
            chk("cpuhold_during_write", 32'(CpuHold), 32'd1);
            if (n_wr == 0) first_wr = cyc;
            last_wr = cyc;
            n_wr++;
        end
        if (Done) begin
            n_done++;
            done_cyc = cyc;
            chk("cpuhold_at_done", 32'(CpuHold), 32'd0);
        end
    end

    function automatic logic [31:0] word_of(input int i);
        return {8'(i), 8'hC3, 8'(255 - i), 8'(i * 3)};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int k;
        logic rdy;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                ByteValid = 1'b0;
                @(posedge clk); #1;
            end
        end
        ByteValid = 1'b1;
        ByteData  = b;
        k = 0;
        do begin
            @(negedge clk);
            rdy = ByteReady;
            if (rdy) last_t = cyc;
            @(posedge clk); #1;
            k++;
        end while (!rdy && k < 100);
        ByteValid = 1'b0;
        if (!rdy) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        @(negedge clk);
        chk("cpuhold_after_start", 32'(CpuHold), 32'd1);
        chk("ready_after_start", 32'(ByteReady), 32'd1);
        chk("error_cleared_by_start", 32'(Error), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int exp_cyc);
        int k = 0;
        while (n_done == 0 && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        chk("done_count", 32'(n_done), 32'd1);
        chk("done_cycle", 32'(done_cyc), 32'(exp_cyc));
        @(negedge clk); #1;
        chk("done_single_pulse", 32'(Done), 32'd0);
        chk("cpuhold_after_done", 32'(CpuHold), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_ctrl"}, 32'({ByteReady, WrEn, CpuHold, Done, Error}), 32'd0);
        chk({nm, "_addr"}, 32'(WrAddr), 32'd0);
        chk({nm, "_data"}, WrData, 32'd0);
    endtask

    initial begin
        int t;
        logic [31:0] w;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1;

        // Basic load, N=2
        clear_stats();
        push_wr(0, 32'h0800_0003);
        push_wr(1, 32'h0C00_001B);
        for (int a = 2; a < 64; a++) push_wr(a, 32'h0);
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
        send_byte(8'h0C, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h1B, 0);
        t = last_t;
        wait_done(t + 64);
        chk("basic_write_count", 32'(n_wr), 32'd64);
        chk("basic_last_write", 32'(last_wr), 32'(t + 63));

        // Empty image
        clear_stats();
        for (int a = 0; a < 64; a++) push_wr(a, 32'h0);
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        t = last_t;
        wait_done(t + 66);
        chk("empty_first_write", 32'(first_wr), 32'(t + 2));
        chk("empty_last_write", 32'(last_wr), 32'(t + 65));
        chk("empty_write_count", 32'(n_wr), 32'd64);

        // Length error, N=65
        clear_stats();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h41, 0);
        @(negedge clk);
        chk("lenerr_error", 32'(Error), 32'd1);
        chk("lenerr_cpuhold", 32'(CpuHold), 32'd0);
        chk("lenerr_ready", 32'(ByteReady), 32'd0);
        ByteValid = 1'b1; ByteData = 8'h55;
        repeat (10) @(negedge clk);
        ByteValid = 1'b0;
        chk("lenerr_no_writes", 32'(n_wr), 32'd0);
        chk("lenerr_sticky", 32'(Error), 32'd1);
        @(posedge clk); #1;

        // Full image with gaps and an ignored Start mid-DATA
        clear_stats();
        for (int i = 0; i < 64; i++) push_wr(i, word_of(i));
        pulse_start();
        send_byte(8'h00, 1); send_byte(8'h40, 1);
        for (int i = 0; i < 64; i++) begin
            w = word_of(i);
            for (int j = 0; j < 4; j++) begin
                send_byte(w[31 - 8*j -: 8], 1);
                if (i == 10 && j == 1) begin
                    Start = 1'b1;
                    @(posedge clk); #1;
                    Start = 1'b0;
                end
            end
        end
        t = last_t;
        wait_done(t + 2);
        chk("full_write_count", 32'(n_wr), 32'd64);
        chk("full_last_write", 32'(last_wr), 32'(t + 1));

        // Reset mid-DATA after two data bytes, then a fresh load
        clear_stats();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h08, 0); send_byte(8'h00, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        ByteValid = 1'b1; ByteData = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle_ready", 32'(ByteReady), 32'd0);
        end
        @(posedge clk); #1;
        ByteValid = 1'b0;
        chk("mid_reset_no_writes", 32'(n_wr), 32'd0);
        push_wr(0, 32'hDEAD_BEEF);
        for (int a = 1; a < 64; a++) push_wr(a, 32'h0);
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        t = last_t;
        wait_done(t + 65);
        chk("reload_write_count", 32'(n_wr), 32'd64);

        // Idle noise without Start
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            ByteValid = i[0];
            ByteData  = 8'(8'h30 + i);
            @(negedge clk);
            chk("idle_ready", 32'(ByteReady), 32'd0);
            chk("idle_cpuhold", 32'(CpuHold), 32'd0);
            @(posedge clk); #1;
        end
        ByteValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_writes", 32'(n_wr), 32'd0);
        chk("idle_no_done", 32'(n_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
